// File: rtl/vector_sequencer.sv
// Vector instruction sequencer: accepts one vector opcode and steps the
// element index across VLEN elements. It produces per-element ALU control,
// vector-register write enables and memory strobes, and stalls the scalar
// pipeline until the instruction completes. DIVV spends DIV_LAT cycles on
// each element.
module vector_sequencer #(
    parameter int VLEN    = 8,
    parameter int DIV_LAT = 4,
    parameter int AW      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [4:0]              opcode,
    input  logic [AW-1:0]           base_addr,
    input  logic                    flush,
    output logic                    elem_valid,
    output logic [$clog2(VLEN)-1:0] elem_idx,
    output logic [3:0]              alu_control,
    output logic                    vreg_we,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic                    stall,
    output logic                    done
);

    localparam int IW = $clog2(VLEN);
    localparam int WW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [IW-1:0] ELEM_LAST = IW'(VLEN - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(DIV_LAT - 1);
    localparam logic          DIV_MULTI = (DIV_LAT > 1);

    localparam logic [4:0] OP_ADDV = 5'b11000;
    localparam logic [4:0] OP_MULV = 5'b11001;
    localparam logic [4:0] OP_DIVV = 5'b11010;
    localparam logic [4:0] OP_REP  = 5'b11011;
    localparam logic [4:0] OP_MOVV = 5'b11100;
    localparam logic [4:0] OP_SVI  = 5'b11101;
    localparam logic [4:0] OP_LVI  = 5'b11110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT_DIV,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [IW-1:0] elem_q;
    logic [WW-1:0] wait_q;
    logic [4:0]    op_q;
    logic [AW-1:0] base_q;

    logic          is_vec_d;
    logic          in_run_d;
    logic          in_wait_d;
    logic          is_div_d;
    logic          is_mem_d;

    function automatic logic [3:0] alu_map(input logic [4:0] op);
        case (op)
            OP_ADDV: alu_map = 4'b0000;
            OP_MULV: alu_map = 4'b0010;
            OP_DIVV: alu_map = 4'b0101;
            OP_REP:  alu_map = 4'b1000;
            OP_MOVV: alu_map = 4'b1001;
            default: alu_map = 4'b0000;
        endcase
    endfunction

    assign is_vec_d  = (opcode >= OP_ADDV) && (opcode <= OP_LVI);
    assign in_run_d  = (state_q == S_RUN);
    assign in_wait_d = (state_q == S_WAIT_DIV);
    assign is_div_d  = (op_q == OP_DIVV);
    assign is_mem_d  = (op_q == OP_SVI) || (op_q == OP_LVI);

    // Sequencer FSM: accept, element stepping, divide wait and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            wait_q  <= '0;
            op_q    <= '0;
            base_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue_valid && !flush && is_vec_d) begin
                        op_q    <= opcode;
                        base_q  <= base_addr;
                        elem_q  <= '0;
                        wait_q  <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        elem_q  <= '0;
                        wait_q  <= '0;
                        state_q <= S_IDLE;
                    end else if (is_div_d && DIV_MULTI) begin
                        wait_q  <= WW'(1);
                        state_q <= S_WAIT_DIV;
                    end else if (elem_q == ELEM_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        elem_q <= elem_q + 1'b1;
                    end
                end
                S_WAIT_DIV: begin
                    if (flush) begin
                        elem_q  <= '0;
                        wait_q  <= '0;
                        state_q <= S_IDLE;
                    end else if (wait_q == WAIT_LAST) begin
                        wait_q <= '0;
                        if (elem_q == ELEM_LAST) begin
                            state_q <= S_DONE;
                        end else begin
                            elem_q  <= elem_q + 1'b1;
                            state_q <= S_RUN;
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: begin
                    // DONE lasts one cycle whether or not flush is high.
                    elem_q  <= '0;
                    wait_q  <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state, counters and latched fields.
    always_comb begin
        issue_ready = (state_q == S_IDLE);
        stall       = in_run_d || in_wait_d;
        done        = (state_q == S_DONE);
        elem_valid  = in_run_d;
        elem_idx    = (in_run_d || in_wait_d) ? elem_q : '0;
        // In RUN a multi-cycle DIVV defers its write to the last wait cycle.
        vreg_we     = (in_run_d && (op_q != OP_SVI) && !(is_div_d && DIV_MULTI))
                   || (in_wait_d && (wait_q == WAIT_LAST));
        mem_we      = in_run_d && (op_q == OP_SVI);
        mem_re      = in_run_d && (op_q == OP_LVI);
        mem_addr    = (in_run_d && is_mem_d)
                    ? base_q + {{(AW-IW){1'b0}}, elem_q} : '0;
        alu_control = (elem_valid || vreg_we) ? alu_map(op_q) : 4'b0000;
    end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Multi-cycle sequencer for vector instructions (ADDV, MULV, DIVV, REP, MOVV, SVI, LVI) in the vector processor execute stage.
- Accepts one issued vector opcode, then steps the element index across VLEN elements, one element per cycle (DIV_LAT cycles per element for DIVV).
- Drives per-element ALU control, vector-register write, and memory read/write strobes with addresses.
- Stalls the scalar pipeline until the instruction completes.

Parameters:
- VLEN, 8, elements per vector register; power of two, at least 2.
- DIV_LAT, 4, cycles per element for DIVV; at least 1.
- AW, 32, memory address width.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, synchronous active-high reset.
- issue_valid, input, 1, an instruction is presented on opcode/base_addr.
- issue_ready, output, 1, sequencer can accept an instruction.
- opcode, input, 5, instruction opcode.
- base_addr, input, AW, base address for SVI/LVI.
- flush, input, 1, synchronous abort of the current instruction.
- elem_valid, output, 1, an element operation starts this cycle.
- elem_idx, output, $clog2(VLEN), current element index.
- alu_control, output, 4, ALU operation for the current element.
- vreg_we, output, 1, write the current element to the destination vector register.
- mem_re, output, 1, memory read strobe (LVI).
- mem_we, output, 1, memory write strobe (SVI).
- mem_addr, output, AW, element memory address.
- stall, output, 1, hold the scalar pipeline.
- done, output, 1, one-cycle completion pulse.

Behaviour:
- Reset: rst sampled high forces state IDLE and clears the counters and all latched fields.
  - All outputs are 0 except issue_ready=1.
  - rst has priority over flush and issue.
- States: IDLE, RUN, WAIT_DIV, DONE.
- issue_ready is 1 only in IDLE. An instruction is accepted when issue_valid and issue_ready are both 1 at a clock edge.
- Vector opcodes are 11000–11110.
  - Any other opcode with issue_valid is ignored: stay in IDLE, no stall, no strobes.
- On accept:
  - Latch opcode and base_addr; elem counter=0; go to RUN.
  - Later changes on the inputs have no effect until the next accept.
- ALU control mapping from the latched opcode:
  - ADDV 0000, MULV 0010, DIVV 0101, REP 1000, MOVV 1001, SVI 0000, LVI 0000.
  - alu_control=0000 whenever elem_valid=0 and vreg_we=0.
- RUN, every cycle:
  - elem_valid=1, elem_idx=counter.
  - mem_addr = latched base_addr + counter, modulo 2^AW (wraps silently).
  - mem_addr=0 for non-memory opcodes.
- RUN, non-DIVV opcodes:
  - vreg_we=1 for all opcodes except SVI; mem_we=1 only for SVI; mem_re=1 only for LVI.
  - The counter increments each cycle. On counter=VLEN-1, go to DONE.
- RUN, DIVV:
  - elem_valid=1 and vreg_we=0 in the RUN cycle.
  - If DIV_LAT=1: vreg_we=1 in that same cycle, and behaviour is identical to the non-DIVV case.
  - Otherwise go to WAIT_DIV with wait counter=1.
- WAIT_DIV:
  - elem_valid=0; elem_idx holds; wait counter increments.
  - When wait counter=DIV_LAT-1: vreg_we=1 in that cycle.
    - If the element counter=VLEN-1, go to DONE.
    - Otherwise increment the element counter and return to RUN.
- DONE: one cycle with done=1, stall=0, all strobes 0; then IDLE.
- stall=1 exactly in RUN and WAIT_DIV.
- Latency, accept at edge T:
  - Non-DIVV: first element at cycle T+1, last element at T+VLEN, done at T+VLEN+1, issue_ready=1 at T+VLEN+2.
  - DIVV: done at T+VLEN*DIV_LAT+1.
- flush: sampled high in RUN, WAIT_DIV or DONE forces IDLE next cycle.
  - No done pulse.
  - Strobes in the flush cycle itself still follow the current state.
  - flush in IDLE blocks an accept in that cycle.
- No back-to-back accept: the next instruction is accepted no earlier than the cycle after DONE.

Test Plan:
- Reset: assert rst 2 cycles mid-RUN (ADDV, element 3) -> next cycle issue_ready=1, stall=0, elem_valid=0, vreg_we=0, done=0.
- ADDV, VLEN=8: accept at T -> elem_valid and vreg_we=1 with elem_idx 0..7 at T+1..T+8, alu_control=0000, stall=1 over the same cycles, done=1 at T+9, issue_ready=1 at T+10.
- DIVV, VLEN=8, DIV_LAT=4 -> elem_valid every 4th cycle, vreg_we on the 4th cycle of each element, alu_control=0101, 8 vreg_we pulses total, done at T+33.
- SVI, base_addr=0xFFFFFFFE -> mem_we=1 with mem_addr FFFFFFFE, FFFFFFFF, 00000000..00000005; vreg_we=0 throughout.
- LVI, base_addr=0x100 -> mem_re=1 and vreg_we=1 with mem_addr 0x100..0x107; mem_we=0.
- Non-vector opcode 00001 with issue_valid=1 -> stays IDLE, stall=0, no strobes. Flush at element 2 of MULV -> IDLE next cycle, no done pulse, a new ADDV is accepted immediately after.
